// File: rtl/green_house_ctrl.sv
// green_house_ctrl: greenhouse climate (avg temp, heater/vent/lamp/humidifier hysteresis), timed pH dosing and door FSM with fault; sensors in, registered actuator drives out
module green_house_ctrl #(
    parameter int N_TEMP        = 4,
    parameter int W             = 8,
    parameter int TEMP_LO       = 25,
    parameter int TEMP_HI       = 40,
    parameter int TEMP_HYST     = 2,
    parameter int LIGHT_ON      = 200,
    parameter int LIGHT_HYST    = 10,
    parameter int HUM_ON        = 50,
    parameter int HUM_HYST      = 5,
    parameter int PH_LO         = 50,
    parameter int PH_HI         = 60,
    parameter int DOSE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 100,
    parameter int TRAVEL_CYCLES = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_TEMP*W-1:0]   tempSen,
    input  logic [W-1:0]          phSen,
    input  logic [W-1:0]          lightSen,
    input  logic [W-1:0]          humiditySen,
    input  logic                  doorPIRIn,
    input  logic                  doorPIROut,
    input  logic                  doorOpenMax,
    input  logic                  doorCloseMax,
    output logic [W-1:0]          temp,
    output logic                  heater,
    output logic                  ventilator,
    output logic                  light,
    output logic                  humidityGenerator,
    output logic                  addAlkali,
    output logic                  addAcidic,
    output logic                  doorOpen,
    output logic                  doorClose,
    output logic                  doorFault
);
    localparam int LG = $clog2(N_TEMP);
    localparam int SW = W + LG;
    localparam int PW = $clog2((DOSE_CYCLES > SETTLE_CYCLES ? DOSE_CYCLES : SETTLE_CYCLES) + 1);
    localparam int DW = $clog2((HOLD_CYCLES > TRAVEL_CYCLES ? HOLD_CYCLES : TRAVEL_CYCLES) + 1);
    typedef logic [W:0] cmp_t;
    localparam cmp_t T_LO_SET = cmp_t'(TEMP_LO);
    localparam cmp_t T_LO_CLR = cmp_t'(TEMP_LO + TEMP_HYST);
    localparam cmp_t T_HI_SET = cmp_t'(TEMP_HI);
    localparam cmp_t T_HI_CLR = cmp_t'(TEMP_HI - TEMP_HYST);
    localparam cmp_t L_SET    = cmp_t'(LIGHT_ON);
    localparam cmp_t L_CLR    = cmp_t'(LIGHT_ON + LIGHT_HYST);
    localparam cmp_t H_SET    = cmp_t'(HUM_ON);
    localparam cmp_t H_CLR    = cmp_t'(HUM_ON + HUM_HYST);
    localparam cmp_t P_LO     = cmp_t'(PH_LO);
    localparam cmp_t P_HI     = cmp_t'(PH_HI);
    localparam logic [PW-1:0] DOSE_M1   = PW'(DOSE_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_M1 = PW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] HOLD_N    = DW'(HOLD_CYCLES);
    localparam logic [DW-1:0] TRAV_M1   = DW'(TRAVEL_CYCLES - 1);

    typedef enum logic [1:0] {P_IDLE, P_DOSE, P_SETTLE} p_state_t;
    typedef enum logic [2:0] {D_CLOSED, D_OPENING, D_HOLD, D_CLOSING, D_FAULT} d_state_t;

    logic [SW-1:0] sum_d, sum_q;
    logic [W-1:0]  ph1_d, ph1_q, light1_d, light1_q, hum1_d, hum1_q, ph2_d, ph2_q, temp_d, temp_q;
    logic          heater_d, heater_q, vent_d, vent_q, lamp_d, lamp_q, hum_d, hum_q;
    p_state_t      p_state_d, p_state_q;
    logic [PW-1:0] p_cnt_d, p_cnt_q;
    logic          alk_d, alk_q, acid_d, acid_q, ph_low, ph_high, p_eval;
    d_state_t      d_state_d, d_state_q;
    logic [DW-1:0] trav_d, trav_q, hold_d, hold_q;
    logic          open_d, open_q, close_d, close_q, fault_d, fault_q, pir;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_TEMP; i++) sum_d = sum_d + SW'(tempSen[i*W +: W]);
        ph1_d    = phSen;
        light1_d = lightSen;
        hum1_d   = humiditySen;
    end

    always_comb begin
        temp_d   = sum_q[SW-1:LG];
        heater_d = ({1'b0, temp_d} < T_LO_SET) ? 1'b1 : ({1'b0, temp_d} >= T_LO_CLR) ? 1'b0 : heater_q;
        vent_d   = ({1'b0, temp_d} > T_HI_SET) ? 1'b1 : ({1'b0, temp_d} <= T_HI_CLR) ? 1'b0 : vent_q;
        lamp_d   = ({1'b0, light1_q} < L_SET) ? 1'b1 : ({1'b0, light1_q} >= L_CLR) ? 1'b0 : lamp_q;
        hum_d    = ({1'b0, hum1_q} < H_SET) ? 1'b1 : ({1'b0, hum1_q} >= H_CLR) ? 1'b0 : hum_q;
        ph2_d    = ph1_q;
    end

    // The last settle cycle evaluates the band directly so a persistent
    // excursion re-doses with exactly SETTLE_CYCLES low cycles in between.
    always_comb begin
        p_state_d = p_state_q;
        alk_d     = alk_q;
        acid_d    = acid_q;
        p_cnt_d   = (p_cnt_q == '0) ? '0 : p_cnt_q - 1'b1;
        ph_low    = {1'b0, ph2_q} < P_LO;
        ph_high   = {1'b0, ph2_q} > P_HI;
        p_eval    = (p_state_q == P_IDLE) || (p_state_q == P_SETTLE && p_cnt_q == '0);
        if (p_eval) begin
            p_state_d = (ph_low || ph_high) ? P_DOSE : P_IDLE;
            p_cnt_d   = DOSE_M1;
            alk_d     = ph_low;
            acid_d    = ph_high;
        end else if (p_state_q == P_DOSE && p_cnt_q == '0) begin
            p_state_d = P_SETTLE;
            p_cnt_d   = SETTLE_M1;
            alk_d     = 1'b0;
            acid_d    = 1'b0;
        end
    end

    always_comb begin
        pir       = doorPIRIn | doorPIROut;
        d_state_d = d_state_q;
        trav_d    = (trav_q == '0) ? '0 : trav_q - 1'b1;
        hold_d    = (hold_q == '0) ? '0 : hold_q - 1'b1;
        case (d_state_q)
            D_CLOSED: if (pir) begin
                d_state_d = D_OPENING;
                trav_d    = TRAV_M1;
            end
            D_OPENING: if (doorOpenMax) begin
                d_state_d = D_HOLD;
                hold_d    = HOLD_N;
            end else if (trav_q == '0) d_state_d = D_FAULT;
            D_HOLD: if (pir) hold_d = HOLD_N;
            else if (hold_q == '0) begin
                d_state_d = D_CLOSING;
                trav_d    = TRAV_M1;
            end
            D_CLOSING: if (pir) begin
                d_state_d = D_OPENING;
                trav_d    = TRAV_M1;
            end else if (doorCloseMax) d_state_d = D_CLOSED;
            else if (trav_q == '0) d_state_d = D_FAULT;
            D_FAULT: if (doorCloseMax && !doorOpenMax) d_state_d = D_CLOSED;
            default: d_state_d = D_FAULT;
        endcase
        if (doorOpenMax && doorCloseMax) d_state_d = D_FAULT;
        open_d  = d_state_d == D_OPENING;
        close_d = d_state_d == D_CLOSING;
        fault_d = fault_q | (d_state_d == D_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sum_q     <= '0;
            ph1_q     <= '0;
            light1_q  <= '0;
            hum1_q    <= '0;
            ph2_q     <= '0;
            temp_q    <= '0;
            heater_q  <= 1'b0;
            vent_q    <= 1'b0;
            lamp_q    <= 1'b0;
            hum_q     <= 1'b0;
            p_state_q <= P_IDLE;
            p_cnt_q   <= '0;
            alk_q     <= 1'b0;
            acid_q    <= 1'b0;
            d_state_q <= D_CLOSED;
            trav_q    <= '0;
            hold_q    <= '0;
            open_q    <= 1'b0;
            close_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            ph1_q     <= ph1_d;
            light1_q  <= light1_d;
            hum1_q    <= hum1_d;
            ph2_q     <= ph2_d;
            temp_q    <= temp_d;
            heater_q  <= heater_d;
            vent_q    <= vent_d;
            lamp_q    <= lamp_d;
            hum_q     <= hum_d;
            p_state_q <= p_state_d;
            p_cnt_q   <= p_cnt_d;
            alk_q     <= alk_d;
            acid_q    <= acid_d;
            d_state_q <= d_state_d;
            trav_q    <= trav_d;
            hold_q    <= hold_d;
            open_q    <= open_d;
            close_q   <= close_d;
            fault_q   <= fault_d;
        end

    assign temp              = temp_q;
    assign heater            = heater_q;
    assign ventilator        = vent_q;
    assign light             = lamp_q;
    assign humidityGenerator = hum_q;
    assign addAlkali         = alk_q;
    assign addAcidic         = acid_q;
    assign doorOpen          = open_q;
    assign doorClose         = close_q;
    assign doorFault         = fault_q;
endmodule

// File: tb/tb_green_house_ctrl.sv
// tb_green_house_ctrl: scoreboard bench with a timeline reference model for green_house_ctrl
module tb_green_house_ctrl;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N*W-1:0] temp_sen;
    logic [W-1:0]   ph_sen, light_sen, hum_sen;
    logic           pir_in, pir_out, open_max, close_max;
    logic [W-1:0]   temp;
    logic           heater, ventilator, light, hum_gen, add_alk, add_acid, door_open, door_close, door_fault;

    green_house_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tempSen(temp_sen), .phSen(ph_sen), .lightSen(light_sen),
        .humiditySen(hum_sen), .doorPIRIn(pir_in), .doorPIROut(pir_out), .doorOpenMax(open_max),
        .doorCloseMax(close_max), .temp(temp), .heater(heater), .ventilator(ventilator), .light(light),
        .humidityGenerator(hum_gen), .addAlkali(add_alk), .addAcidic(add_acid), .doorOpen(door_open),
        .doorClose(door_close), .doorFault(door_fault)
    );

    typedef struct packed {
        logic [7:0] temp;
        logic heater, vent, lamp, hum, alk, acid, dopen, dclose, dfault;
    } out_t;

    out_t act, mon_exp;
    assign act = {temp, heater, ventilator, light, hum_gen, add_alk, add_acid, door_open, door_close, door_fault};

    out_t sb[$];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got == expv) passed++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, expv);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && sb.size() > 0) begin
            mon_exp = sb.pop_front();
            chk("scoreboard", int'(act), int'(mon_exp));
        end
    end

    // Reference model: sample history per edge, hysteresis flags, and deadline timestamps.
    typedef enum {M_CLOSED, M_OPENING, M_HOLD, M_CLOSING, M_FAULT} m_door_t;
    int avg_h[$], ph_h[$], li_h[$], hu_h[$];
    int cyc, free_at, dose_start, travel_end, hold_end;
    bit m_heat, m_vent, m_lamp, m_hum, dose_alk, m_fault;
    m_door_t md;

    function automatic void model_reset();
        cyc = 0;
        avg_h.delete(); ph_h.delete(); li_h.delete(); hu_h.delete();
        m_heat = 0; m_vent = 0; m_lamp = 0; m_hum = 0; m_fault = 0;
        free_at = 0; dose_start = -1000; dose_alk = 0;
        md = M_CLOSED; travel_end = 0; hold_end = 0;
    endfunction

    function automatic void model_edge();
        int s = 0;
        int t, l, h, p;
        bit pir, dosing;
        out_t e;
        for (int i = 0; i < N; i++) s += int'(temp_sen[i*W +: W]);
        avg_h.push_back(s / N);
        ph_h.push_back(int'(ph_sen));
        li_h.push_back(int'(light_sen));
        hu_h.push_back(int'(hum_sen));
        t = (cyc >= 1) ? avg_h[cyc-1] : 0;
        l = (cyc >= 1) ? li_h[cyc-1] : 0;
        h = (cyc >= 1) ? hu_h[cyc-1] : 0;
        p = (cyc >= 2) ? ph_h[cyc-2] : 0;
        if (t < 25) m_heat = 1; else if (t >= 27) m_heat = 0;
        if (t > 40) m_vent = 1; else if (t <= 38) m_vent = 0;
        if (l < 200) m_lamp = 1; else if (l >= 210) m_lamp = 0;
        if (h < 50) m_hum = 1; else if (h >= 55) m_hum = 0;
        if (cyc >= free_at && (p < 50 || p > 60)) begin
            dose_start = cyc;
            dose_alk = p < 50;
            free_at = cyc + 4 + 16;
        end
        dosing = cyc >= dose_start && cyc < dose_start + 4;
        pir = pir_in | pir_out;
        case (md)
            M_CLOSED: if (pir) begin md = M_OPENING; travel_end = cyc + 50; end
            M_OPENING: if (open_max) begin md = M_HOLD; hold_end = cyc + 101; end
                       else if (cyc >= travel_end) md = M_FAULT;
            M_HOLD: if (pir) hold_end = cyc + 101;
                    else if (cyc >= hold_end) begin md = M_CLOSING; travel_end = cyc + 50; end
            M_CLOSING: if (pir) begin md = M_OPENING; travel_end = cyc + 50; end
                       else if (close_max) md = M_CLOSED;
                       else if (cyc >= travel_end) md = M_FAULT;
            M_FAULT: if (close_max && !open_max) md = M_CLOSED;
        endcase
        if (open_max && close_max) md = M_FAULT;
        if (md == M_FAULT) m_fault = 1;
        e.temp = t[7:0];
        e.heater = m_heat; e.vent = m_vent; e.lamp = m_lamp; e.hum = m_hum;
        e.alk = dosing && dose_alk; e.acid = dosing && !dose_alk;
        e.dopen = md == M_OPENING; e.dclose = md == M_CLOSING; e.dfault = m_fault;
        sb.push_back(e);
        cyc++;
    endfunction

    task automatic cycle();
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) temp_sen[i*W +: W] = v[7:0];
    endtask

    // Reset lands between clock edges so the outputs must drop asynchronously.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk("async_reset", int'(act), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    bit alk_rec[60];
    int n, r1, f1, r2;

    initial begin
        set_all(30); ph_sen = 55; light_sen = 220; hum_sen = 60;
        pir_in = 0; pir_out = 0; open_max = 0; close_max = 0;
        @(negedge clk);
        do_reset();
        // climate hysteresis
        repeat (3) cycle();
        set_all(20); repeat (2) cycle();
        chk("temp20", int'(temp), 20); chk("heater20", int'(heater), 1);
        set_all(26); repeat (2) cycle();
        chk("heater26_hold", int'(heater), 1);
        set_all(27); repeat (2) cycle();
        chk("heater27_clear", int'(heater), 0);
        temp_sen = {8'd42, 8'd41, 8'd41, 8'd41}; repeat (2) cycle();
        chk("temp41_trunc", int'(temp), 41); chk("vent41", int'(ventilator), 1);
        set_all(38); repeat (2) cycle();
        chk("vent38_clear", int'(ventilator), 0);
        set_all(30); repeat (25) cycle();
        // pH dosing cadence
        ph_sen = 45;
        for (int i = 0; i < 60; i++) begin cycle(); alk_rec[i] = add_alk; end
        r1 = -1; f1 = -1; r2 = -1;
        for (int i = 1; i < 60; i++) begin
            if (alk_rec[i] && !alk_rec[i-1] && r1 < 0) r1 = i;
            else if (!alk_rec[i] && alk_rec[i-1] && r1 >= 0 && f1 < 0) f1 = i;
            else if (alk_rec[i] && !alk_rec[i-1] && f1 >= 0 && r2 < 0) r2 = i;
        end
        chk("ph_latency", r1, 2);
        chk("dose_len", f1 - r1, 4);
        chk("settle_len", r2 - f1, 16);
        ph_sen = 55; repeat (30) cycle();
        chk("ph_inband_idle", int'({add_alk, add_acid}), 0);
        // door open / hold / close
        pir_in = 1; cycle(); pir_in = 0;
        chk("door_opening", int'({door_open, door_close}), 2);
        repeat (9) cycle();
        open_max = 1; cycle(); open_max = 0;
        repeat (59) cycle();
        chk("door_holding", int'({door_open, door_close}), 0);
        pir_in = 1; cycle(); pir_in = 0;
        n = 0;
        while (n < 300 && !door_close) begin cycle(); n++; end
        chk("hold_to_close", n, 101);
        repeat (5) cycle();
        pir_out = 1; cycle(); pir_out = 0;
        chk("reversal", int'({door_open, door_close}), 2);
        open_max = 1; cycle(); open_max = 0;
        n = 0;
        while (n < 300 && !door_close) begin cycle(); n++; end
        close_max = 1; cycle(); close_max = 0;
        chk("door_closed", int'({door_open, door_close, door_fault}), 0);
        // travel timeout fault
        pir_in = 1; cycle(); pir_in = 0;
        n = 1;
        while (n < 300 && !door_fault) begin cycle(); if (door_open) n++; end
        chk("travel_timeout", n, 50);
        chk("fault_drives", int'({door_open, door_close, door_fault}), 1);
        close_max = 1; cycle(); close_max = 0;
        pir_in = 1; cycle(); pir_in = 0;
        chk("fault_sticky_reopen", int'({door_open, door_fault}), 3);
        do_reset();
        open_max = 1; close_max = 1; cycle(); open_max = 0; close_max = 0;
        chk("both_limits", int'(door_fault), 1);
        repeat (3) cycle();
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++)
                temp_sen[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(15, 50));
            if ($urandom_range(0, 7) == 0) ph_sen = 8'($urandom_range(40, 70));
            light_sen = 8'($urandom_range(185, 225));
            hum_sen = 8'($urandom_range(40, 65));
            pir_in = $urandom_range(0, 19) == 0;
            pir_out = $urandom_range(0, 29) == 0;
            open_max = $urandom_range(0, 14) == 0;
            close_max = $urandom_range(0, 14) == 0;
            if ($urandom_range(0, 399) == 0) do_reset();
            else cycle();
        end
        pir_in = 0; pir_out = 0; open_max = 0; close_max = 0;
        repeat (3) cycle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/green_house_ctrl.md
# green_house_ctrl

Clocked, parametrised greenhouse climate and door controller for N temperature sensors. It averages the temperature sensors and drives the heater, ventilator, lamp and humidifier with hysteresis. pH correction is applied as timed dose/settle pulses. The door is run by a limit-switch FSM with a hold timer, obstacle reversal and a travel-timeout fault. It sits between the raw sensor front-end and the actuator drivers.

## Interface
Parameters:
- N_TEMP, 4: number of temperature sensors; power of two, 2..16.
- W, 8: width of every sensor word.
- TEMP_LO, 25 / TEMP_HI, 40 / TEMP_HYST, 2: heater and ventilator thresholds. Constraint: TEMP_LO+TEMP_HYST < TEMP_HI-TEMP_HYST.
- LIGHT_ON, 200 / LIGHT_HYST, 10: lamp threshold and hysteresis.
- HUM_ON, 50 / HUM_HYST, 5: humidifier threshold and hysteresis.
- PH_LO, 50 / PH_HI, 60: pH dead band.
- DOSE_CYCLES, 4 / SETTLE_CYCLES, 16: dosing pulse length and post-dose lockout.
- HOLD_CYCLES, 100: door open-hold time.
- TRAVEL_CYCLES, 50: maximum door travel time.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- tempSen  in  N_TEMP*W  packed sensors; sensor i is [i*W +: W].
- phSen, lightSen, humiditySen  in  W each  sensor words, unsigned.
- doorPIRIn, doorPIROut  in  1  presence detectors.
- doorOpenMax, doorCloseMax  in  1  end-of-travel limit switches.
- temp  out  W  registered average temperature.
- heater, ventilator, light, humidityGenerator  out  1  climate actuators.
- addAlkali, addAcidic  out  1  dosing valves.
- doorOpen, doorClose  out  1  door motor drive.
- doorFault  out  1  sticky travel or limit fault.

## Operation
- Stage 1 registers:
  - sum of all tempSen words, width W+log2(N_TEMP), with no overflow possible;
  - copies of phSen, lightSen and humiditySen.
- Stage 2 computes temp = sum >> log2(N_TEMP) (truncating) and all climate decisions from the stage-1 values.
- Heater: sets when temp < TEMP_LO; clears when temp >= TEMP_LO+TEMP_HYST; otherwise holds.
- Ventilator: sets when temp > TEMP_HI; clears when temp <= TEMP_HI-TEMP_HYST; otherwise holds. Heater and ventilator are never both 1.
- Light: sets when lightSen < LIGHT_ON; clears when lightSen >= LIGHT_ON+LIGHT_HYST.
- Humidifier: same rule using HUM_ON and HUM_HYST.
- All compares are unsigned.
- pH FSM, states P_IDLE, P_DOSE, P_SETTLE:
  - P_IDLE: ph < PH_LO → P_DOSE with addAlkali=1. ph > PH_HI → P_DOSE with addAcidic=1. Otherwise stay.
  - P_DOSE: the selected valve stays high for exactly DOSE_CYCLES cycles, then → P_SETTLE. A pH change during P_DOSE does not switch valves.
  - P_SETTLE: both valves 0 for SETTLE_CYCLES cycles, then → P_IDLE, which re-evaluates.
- Door FSM, states D_CLOSED, D_OPENING, D_HOLD, D_CLOSING, D_FAULT:
  - D_CLOSED: doorPIRIn | doorPIROut → D_OPENING.
  - D_OPENING: doorOpen=1. doorOpenMax → D_HOLD with the hold counter loaded to HOLD_CYCLES. TRAVEL_CYCLES cycles without the limit → D_FAULT.
  - D_HOLD: any PIR reloads the hold counter. When the counter reaches 0 → D_CLOSING.
  - D_CLOSING: doorClose=1. Any PIR → D_OPENING (reversal); the travel counter restarts. doorCloseMax → D_CLOSED. Timeout → D_FAULT.
  - Any state: doorOpenMax & doorCloseMax both high → D_FAULT.
  - D_FAULT: doorFault=1; doorOpen=doorClose=0. Exits to D_CLOSED only when doorCloseMax=1 and doorOpenMax=0; doorFault stays 1 until reset.
- doorOpen and doorClose are never both 1.

## Timing
- Reset, asynchronous: all outputs 0, including temp=0. Pipeline registers and counters are cleared; FSMs go to P_IDLE and D_CLOSED.
- Reset mid-dose or mid-travel drops the valve or motor immediately, without waiting for a clock edge.
- Climate outputs and temp update 2 cycles after a sensor change.
- pH valves assert 3 cycles after the out-of-band sample: 2 pipeline stages plus the FSM register.
- Door outputs are registered: 1 cycle from the PIR or limit edge.
- Hysteresis boundaries are exact: temp == TEMP_LO does not set the heater; temp == TEMP_LO+TEMP_HYST clears it.
- Counters saturate at 0 and never wrap.

## Test plan
- All tempSen=20 → cycle 2: temp=20, heater=1. Then all 26 → heater stays 1. Then all 27 → heater=0.
- tempSen={41,41,41,42} → temp=41 (truncated), ventilator=1. Then all 38 → ventilator=0.
- phSen=45 held → addAlkali high for exactly 4 cycles, low for 16, then high again. phSen=55 → no dosing.
- PIR pulse → doorOpen. doorOpenMax at cycle 10 → hold. PIR at hold cycle 60 → doorClose at 160+1. doorCloseMax → closed.
- During D_CLOSING assert doorPIRIn → next cycle doorOpen=1, doorClose=0.
- D_OPENING with no limit for 50 cycles → doorFault=1, both drives 0. doorCloseMax → D_CLOSED with doorFault still 1. Asserting rst_n low clears it asynchronously.
